// File: rtl/encoder_83_irq.sv
// encoder_83_irq: registered 8-to-3 active-low priority encoder with request
// latching, valid/ack handshake and 74HC148-style cascade outputs (GS_n, EO_n).
// Optional feature macro: PENDING_LATCH_EN
//   defined   -> pending bits are sticky until their code is acked
//   undefined -> pending bits follow the live request levels every edge
module encoder_83_irq (
  input  logic clk,
  input  logic rst_n,
  input  logic EI_n,
  input  logic I0_n,
  input  logic I1_n,
  input  logic I2_n,
  input  logic I3_n,
  input  logic I4_n,
  input  logic I5_n,
  input  logic I6_n,
  input  logic I7_n,
  input  logic ack,
  output logic A2_n,
  output logic A1_n,
  output logic A0_n,
  output logic GS_n,
  output logic EO_n,
  output logic valid
);

  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [7:0] pend_q, pend_d;
  logic [2:0] idx_q, idx_d;
  logic       eo_n_q, eo_n_d;

  logic [7:0] req_n;
  logic [7:0] set_v;
  logic [7:0] cand;
  logic [2:0] hi_idx;

  assign req_n = {I7_n, I6_n, I5_n, I4_n, I3_n, I2_n, I1_n, I0_n};

  // Requests this edge and the set of bits eligible for presentation.
  // Without sticky latching, a bit must still be requested to be presented,
  // so a request withdrawn before presentation is dropped.
  always_comb begin
    set_v = EI_n ? 8'h00 : ~req_n;
`ifdef PENDING_LATCH_EN
    cand  = pend_q;
`else
    cand  = pend_q & set_v;
`endif
  end

  // Highest set candidate bit wins (bit 7 has top priority).
  always_comb begin
    hi_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (cand[i]) hi_idx = 3'(i);
    end
  end

  // Next-state: pending update, handshake FSM, cascade enable-out.
  always_comb begin
`ifdef PENDING_LATCH_EN
    pend_d  = pend_q | set_v;
`else
    pend_d  = set_v;
`endif
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if ((|cand) && !EI_n) begin
          idx_d   = hi_idx;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        // Code stays frozen until ack; clear beats a same-cycle set.
        if (ack) begin
          pend_d[idx_q] = 1'b0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    eo_n_d = ~(!EI_n && (state_q == IDLE) && (pend_q == 8'h00));
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= 8'h00;
      idx_q   <= 3'd0;
      eo_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      eo_n_q  <= eo_n_d;
    end
  end

  // Outputs decode straight from flops, so reset reaches them without a clock.
  always_comb begin
    valid             = (state_q == PRESENT);
    GS_n              = ~valid;
    {A2_n, A1_n, A0_n} = valid ? ~idx_q : 3'b111;
    EO_n              = eo_n_q;
  end

endmodule

// File: tb/tb_encoder_83_irq.sv
// Directed testbench for encoder_83_irq; expectations are hand-computed.
module tb_encoder_83_irq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       EI_n;
  logic [7:0] req_n;
  logic       ack;
  logic       A2_n, A1_n, A0_n, GS_n, EO_n, valid;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  encoder_83_irq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .EI_n  (EI_n),
    .I0_n  (req_n[0]),
    .I1_n  (req_n[1]),
    .I2_n  (req_n[2]),
    .I3_n  (req_n[3]),
    .I4_n  (req_n[4]),
    .I5_n  (req_n[5]),
    .I6_n  (req_n[6]),
    .I7_n  (req_n[7]),
    .ack   (ack),
    .A2_n  (A2_n),
    .A1_n  (A1_n),
    .A0_n  (A0_n),
    .GS_n  (GS_n),
    .EO_n  (EO_n),
    .valid (valid)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Check valid, GS_n and the code together.
  task automatic chk_out(input string tag, input logic exp_v, input logic [2:0] exp_a);
    chk({tag, ".valid"}, {7'd0, valid}, {7'd0, exp_v});
    chk({tag, ".gs_n"},  {7'd0, GS_n},  {7'd0, ~exp_v});
    chk({tag, ".a_n"},   {5'd0, A2_n, A1_n, A0_n}, {5'd0, exp_a});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse between edges; leaves inputs idle.
  task automatic do_reset();
    EI_n  = 1'b1;
    req_n = 8'hFF;
    ack   = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    EI_n  = 1'b1;
    req_n = 8'hFF;
    ack   = 1'b0;
    #12;
    chk_out("reset", 1'b0, 3'b111);
    chk("reset.eo_n", {7'd0, EO_n}, 8'd1);
    rst_n = 1'b1;

    // Indices 5 and 3 held: 5 first, then 3 after a one-cycle gap.
    do_reset();
    EI_n = 1'b0;
    req_n = 8'b1101_0111;
    tick();
    chk_out("t1.lat1", 1'b0, 3'b111);
    tick();
    chk_out("t1.idx5", 1'b1, 3'b010);
    chk("t1.eo_n", {7'd0, EO_n}, 8'd1);
    ack = 1'b1;
    tick();
    chk_out("t1.gap", 1'b0, 3'b111);
    ack = 1'b0;
    tick();
    chk_out("t1.idx3", 1'b1, 3'b100);

    // Higher priority arriving mid-present waits for ack.
    do_reset();
    EI_n = 1'b0;
    req_n = 8'b1111_1011;
    tick();
    tick();
    chk_out("t2.idx2", 1'b1, 3'b101);
    req_n = 8'b0111_1011;
    tick();
    chk_out("t2.frozen1", 1'b1, 3'b101);
    EI_n = 1'b1;
    tick();
    chk_out("t2.frozen_ei", 1'b1, 3'b101);
    EI_n = 1'b0;
    ack = 1'b1;
    tick();
    chk_out("t2.gap", 1'b0, 3'b111);
    ack = 1'b0;
    tick();
    chk_out("t2.idx7", 1'b1, 3'b000);

    // One-cycle pulse on index 6.
    do_reset();
    EI_n = 1'b0;
    req_n = 8'b1011_1111;
    tick();
    req_n = 8'hFF;
    tick();
`ifdef PENDING_LATCH_EN
    chk_out("t3.pulse", 1'b1, 3'b001);
    tick();
    chk_out("t3.hold", 1'b1, 3'b001);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk_out("t3.acked", 1'b0, 3'b111);
`else
    chk_out("t3.pulse", 1'b0, 3'b111);
    tick();
    chk_out("t3.hold", 1'b0, 3'b111);
    tick();
    chk_out("t3.idle", 1'b0, 3'b111);
`endif
    tick();
    chk_out("t3.empty", 1'b0, 3'b111);

    // Disabled input: nothing latched, EO_n high; then enabled and empty.
    do_reset();
    EI_n = 1'b1;
    req_n = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4.dis.valid", {7'd0, valid}, 8'd0);
      chk("t4.dis.eo_n",  {7'd0, EO_n},  8'd1);
    end
    req_n = 8'hFF;
    EI_n = 1'b0;
    tick();
    chk("t4.en.eo_n", {7'd0, EO_n}, 8'd0);
    chk("t4.en.valid", {7'd0, valid}, 8'd0);

    // Asynchronous reset while presenting.
    do_reset();
    EI_n = 1'b0;
    req_n = 8'b1110_1111;
    tick();
    tick();
    chk_out("t5.idx4", 1'b1, 3'b011);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("t5.async", 1'b0, 3'b111);
    chk("t5.async.eo_n", {7'd0, EO_n}, 8'd1);
    req_n = 8'hFF;
    #1;
    rst_n = 1'b1;
    tick();
    chk("t5.post.eo_n", {7'd0, EO_n}, 8'd0);
    chk_out("t5.post", 1'b0, 3'b111);
    tick();
    chk_out("t5.post2", 1'b0, 3'b111);

    // Tied-high ack with indices 0 and 1 held: alternating pulses.
    do_reset();
    EI_n = 1'b0;
    ack = 1'b1;
    req_n = 8'b1111_1100;
    tick();
    chk_out("t6.lat", 1'b0, 3'b111);
    tick();
    chk_out("t6.idx1a", 1'b1, 3'b110);
    tick();
    chk_out("t6.gap1", 1'b0, 3'b111);
    tick();
    chk_out("t6.idx0", 1'b1, 3'b111);
    tick();
    chk_out("t6.gap2", 1'b0, 3'b111);
    tick();
    chk_out("t6.idx1b", 1'b1, 3'b110);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
